// File: rtl/instr_issue_queue.sv
`default_nettype none
// ============================================================================
// instr_issue_queue : FIFO-buffered issuer of {func,in1,in2} words to the
//                     processor control state machine, with stuck-op watchdog
// Revision 1.0
// ============================================================================
module instr_issue_queue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned W_FUNC  = 4,
  parameter int unsigned W_REG   = 3,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [W_FUNC-1:0]        wr_func,
  input  logic [W_REG-1:0]         wr_in1,
  input  logic [W_REG-1:0]         wr_in2,
  output logic [W_FUNC-1:0]        func,
  output logic [W_REG-1:0]         input1,
  output logic [W_REG-1:0]         input2,
  output logic                     start,
  input  logic                     done,
  output logic                     busy,
  output logic                     err,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned TMR_W  = $clog2(TIMEOUT);
  localparam int unsigned WORD_W = W_FUNC + 2 * W_REG;
  localparam logic [PTR_W:0]   LVL_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ERR   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   mem_q [DEPTH];
  logic [WORD_W-1:0]   mem_d [DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]      level_q, level_d;
  logic [W_FUNC-1:0]   func_q, func_d;
  logic [W_REG-1:0]    in1_q, in1_d;
  logic [W_REG-1:0]    in2_q, in2_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                err_q, err_d;

  logic                push;
  logic                pop;
  logic [WORD_W-1:0]   head;
  logic [W_FUNC-1:0]   head_func;
  logic [W_REG-1:0]    head_in1;
  logic [W_REG-1:0]    head_in2;

  assign wr_ready  = (level_q != LVL_FULL) & ~flush;
  assign head      = mem_q[rd_ptr_q];
  assign head_func = head[WORD_W-1 -: W_FUNC];
  assign head_in1  = head[2*W_REG-1 -: W_REG];
  assign head_in2  = head[W_REG-1:0];

  always_comb begin
    state_d  = state_q;
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    func_d   = func_q;
    in1_d    = in1_q;
    in2_d    = in2_q;
    timer_d  = timer_q;
    err_d    = err_q;
    push     = wr_valid & wr_ready;
    pop      = 1'b0;

    if (flush) begin
      // input1/input2 are deliberately left holding their last values
      state_d  = S_IDLE;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
      func_d   = '0;
      timer_d  = '0;
      err_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (level_q != '0) begin
            pop = 1'b1;
            // a zero func is a NOP: consumed without ever reaching the FSM
            if (head_func != '0) begin
              func_d  = head_func;
              in1_d   = head_in1;
              in2_d   = head_in2;
              state_d = S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          timer_d = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (done) begin
            func_d  = '0;
            state_d = S_IDLE;
          end else if (timer_q == TMR_LAST) begin
            err_d   = 1'b1;
            func_d  = '0;
            state_d = S_ERR;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        S_ERR: begin
          state_d = S_ERR;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase

      if (push) begin
        mem_d[wr_ptr_q] = {wr_func, wr_in1, wr_in2};
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      level_d = level_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      func_q   <= '0;
      in1_q    <= '0;
      in2_q    <= '0;
      timer_q  <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      func_q   <= func_d;
      in1_q    <= in1_d;
      in2_q    <= in2_d;
      timer_q  <= timer_d;
      err_q    <= err_d;
      mem_q    <= mem_d;
    end
  end

  assign func   = func_q;
  assign input1 = in1_q;
  assign input2 = in2_q;
  assign start  = (state_q == S_ISSUE);
  assign busy   = (state_q != S_IDLE);
  assign err    = err_q;
  assign level  = level_q;

endmodule
`default_nettype wire
